param_sync_fifo: RTL and testbench
==================================

// Module: param_sync_fifo
// PURPOSE
//  Parametrised single-clock FIFO, successor to the fixed 8x16 buffer.
//  Generic data width and power-of-2 depth; all DEPTH entries usable.
//  Adds occupancy count, programmable almost-full/empty, overflow/underflow pulses.
//  Sits between any producer/consumer pair in one clock domain.
// PARAMETERS
//  DATA_W     8     data word width in bits (>=1)
//  DEPTH      16    number of entries; power of 2, >=4
//  AF_THRESH  12    almost_full asserted when count >= AF_THRESH (1..DEPTH-1)
//  AE_THRESH  4     almost_empty asserted when count <= AE_THRESH (1..DEPTH-1)
// PORTS
//  clk           in   1                  rising-edge clock
//  rst_n         in   1                  asynchronous, active-low reset
//  w_en          in   1                  write request
//  data_in       in   DATA_W             write data, sampled with w_en
//  r_en          in   1                  read request
//  data_out      out  DATA_W             read data, registered
//  rd_valid      out  1                  data_out updated this cycle (1-cycle pulse)
//  full          out  1                  count == DEPTH
//  empty         out  1                  count == 0
//  almost_full   out  1                  count >= AF_THRESH
//  almost_empty  out  1                  count <= AE_THRESH
//  count         out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
//  overflow      out  1                  1-cycle pulse: w_en while full (write dropped)
//  underflow     out  1                  1-cycle pulse: r_en while empty (read dropped)
// BEHAVIOUR
//  - Reset (rst_n low, async assert, sync deassert at board level): wr_ptr=rd_ptr=0,
//    count=0, data_out=0, rd_valid=0, overflow=underflow=0; empty=1, almost_empty=1,
//    full=0, almost_full=0. Memory contents not reset.
//  - Pointers ADDR_W+1 bits (ADDR_W=$clog2(DEPTH)); the MSB is the wrap bit.
//    empty: ptrs equal; full: addr bits equal, wrap bits differ.
//  - Write accept = w_en & ~full: mem[wr_ptr] <= data_in, wr_ptr+1 (natural wrap).
//  - Read accept = r_en & ~empty: data_out <= mem[rd_ptr], rd_ptr+1, rd_valid=1
//    next cycle. Read latency = 1 clk. data_out holds its value when no read occurs.
//  - Flags are evaluated from pre-edge state: no write-through when full,
//    no read-through when empty (bypass not supported).
//  - Both accepted in the same cycle: count unchanged, both pointers advance.
//  - count: +1 on write-only, -1 on read-only, held otherwise; never exceeds DEPTH.
//  - full/empty/almost_* are combinational from registered count/pointers; they
//    reflect the new state in the cycle after the accepting edge.
//  - overflow/underflow registered, high for exactly one cycle per offending
//    request; FIFO state unchanged by a dropped request.
//  - Reset mid-operation: all state is cleared immediately; the first read after
//    reset returns the first word written after reset.
// STRUCTURE
//  - fifo_pkg: clog2-based ADDR_W/CNT_W helper functions, DEPTH power-of-2 check.
//  - Sub-module fifo_mem: DATA_W x DEPTH simple dual-port array, one sync write
//    port and one registered read port, no reset. The top level holds pointers,
//    count, flags and pulses.
//  - Elaboration-time assertions: DEPTH power of 2; thresholds within range.
// TESTING (DATA_W=8, DEPTH=16, AF=12, AE=4)
//  1 Reset: rst_n=0 mid-traffic -> count=0, empty=1, almost_empty=1, data_out=0 async.
//  2 Fill: write 0x00..0x0F -> full=1 after 16th, almost_full from count 12; 17th
//    write 0xAA -> overflow pulse, count=16, 0xAA never read back.
//  3 Drain: 16 reads -> data_out 0x00..0x0F in order, each 1 clk after r_en with
//    rd_valid; 17th read -> underflow pulse, data_out stays 0x0F.
//  4 Simultaneous: count=5, w_en&r_en for 20 cycles -> count stays 5, order kept,
//    pointers wrap cleanly past 15->0.
//  5 Boundaries: full + w_en&r_en -> read accepted, write dropped (overflow), count=15;
//    empty + w_en&r_en -> write accepted, underflow, count=1.
//  6 Random: 10k cycles of random w_en/r_en against a scoreboard queue; count
//    and flags match the model every cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and types for the parameterised synchronous FIFO.
// Pointer/count widths are derived here so every FIFO file sizes them the same way.
package fifo_pkg;

    function automatic int addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_mem.sv
// DATA_W x DEPTH simple dual-port storage: one synchronous write port and one
// registered read port. There is no reset, so the array can map onto block RAM.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [addr_w(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [addr_w(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and overflow/underflow pulses.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    w_en,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    r_en,
    output logic [DATA_W-1:0]       data_out,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    generate
        if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
            $error("param_sync_fifo: DEPTH must be a power of 2 and >= 4");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH - 1) begin : g_bad_af
            $error("param_sync_fifo: AF_THRESH must be in 1..DEPTH-1");
        end
        if (AE_THRESH < 1 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
            $error("param_sync_fifo: AE_THRESH must be in 1..DEPTH-1");
        end
        if (DATA_W < 1) begin : g_bad_dw
            $error("param_sync_fifo: DATA_W must be >= 1");
        end
    endgenerate

    logic [ADDR_W:0]    wr_ptr, rd_ptr;
    logic               wr_acc, rd_acc;
    logic               rd_seen;
    logic [DATA_W-1:0]  mem_rdata;
    fifo_flags_t        flags;

    // Extra MSB on each pointer is the wrap bit that separates full from empty.
    always_comb begin
        flags.empty        = (wr_ptr == rd_ptr);
        flags.full         = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                             (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
        flags.almost_full  = (count >= CNT_W'(AF_THRESH));
        flags.almost_empty = (count <= CNT_W'(AE_THRESH));
    end

    assign full         = flags.full;
    assign empty        = flags.empty;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;

    assign wr_acc = w_en & ~flags.full;
    assign rd_acc = r_en & ~flags.empty;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rd_seen   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + (ADDR_W+1)'(1);
                rd_seen <= 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            rd_valid  <= rd_acc;
            overflow  <= w_en & flags.full;
            underflow <= r_en & flags.empty;
        end
    end

    // The storage read register has no reset; mask it to zero until the first
    // read after reset so data_out still clears asynchronously.
    assign data_out = rd_seen ? mem_rdata : '0;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed + random bench for param_sync_fifo (8x16, AF=12, AE=4) with a queue model.
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    int errors = 0;
    int checks = 0;

    // behavioural model
    logic [7:0] q[$];
    logic [7:0] exp_dout = '0;
    logic       exp_vld = 1'b0, exp_ovf = 1'b0, exp_unf = 1'b0;
    bit         chk_on = 1'b0;

    param_sync_fifo #(.DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4)) dut (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout = '0;
        exp_vld  = 1'b0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    task automatic model_step(input logic w, input logic [7:0] d, input logic r);
        bit f, e;
        f = (q.size() == 16);
        e = (q.size() == 0);
        exp_ovf = w && f;
        exp_unf = r && e;
        exp_vld = r && !e;
        if (r && !e) exp_dout = q.pop_front();
        if (w && !f) q.push_back(d);
    endtask

    // one clock: drive at negedge, model advances at posedge, ends at next negedge
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        w_en = w; data_in = d; r_en = r;
        @(posedge clk);
        if (rst_n) model_step(w, d, r);
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("count",        int'(count),        q.size());
            chk("full",         int'(full),         int'(q.size() == 16));
            chk("empty",        int'(empty),        int'(q.size() == 0));
            chk("almost_full",  int'(almost_full),  int'(q.size() >= 12));
            chk("almost_empty", int'(almost_empty), int'(q.size() <= 4));
            chk("rd_valid",     int'(rd_valid),     int'(exp_vld));
            chk("data_out",     int'(data_out),     int'(exp_dout));
            chk("overflow",     int'(overflow),     int'(exp_ovf));
            chk("underflow",    int'(underflow),    int'(exp_unf));
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        model_reset();
        chk_on = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_ae",    int'(almost_empty), 1);
        chk("rst_dout",  int'(data_out), 0);
        rst_n = 1'b1;

        // fill
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
            chk("fill_count", int'(count), i + 1);
            chk("fill_af",    int'(almost_full), int'(i + 1 >= 12));
            chk("fill_full",  int'(full), int'(i == 15));
        end
        chk("model_size_full", q.size(), 16);
        step(1'b1, 8'hAA, 1'b0);
        chk("ovf_pulse", int'(overflow), 1);
        chk("ovf_count", int'(count), 16);
        step(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", int'(overflow), 0);

        // drain
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain_data",  int'(data_out), i);
            chk("drain_valid", int'(rd_valid), 1);
        end
        step(1'b0, 8'h00, 1'b1);
        chk("unf_pulse", int'(underflow), 1);
        chk("unf_hold",  int'(data_out), 'h0F);
        chk("unf_valid", int'(rd_valid), 0);
        chk("unf_empty", int'(empty), 1);

        // simultaneous read/write at count 5, wrapping the pointers
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h30 + i), 1'b1);
            chk("simul_count", int'(count), 5);
            chk("simul_data",  int'(data_out), (i < 5) ? ('h20 + i) : ('h30 + i - 5));
        end

        // full boundary: read accepted, write dropped
        for (int i = 0; i < 11; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        chk("bnd_full", int'(full), 1);
        step(1'b1, 8'hBB, 1'b1);
        chk("bnd_full_count", int'(count), 15);
        chk("bnd_full_ovf",   int'(overflow), 1);
        chk("bnd_full_data",  int'(data_out), 'h3F);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
        chk("bnd_drained", int'(empty), 1);

        // empty boundary: write accepted, read dropped
        step(1'b1, 8'hCC, 1'b1);
        chk("bnd_empty_count", int'(count), 1);
        chk("bnd_empty_unf",   int'(underflow), 1);
        chk("bnd_empty_vld",   int'(rd_valid), 0);
        step(1'b0, 8'h00, 1'b1);
        chk("bnd_empty_data",  int'(data_out), 'hCC);

        // asynchronous reset in the middle of traffic
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h70 + i), i[0]);
        w_en = 1'b1; data_in = 8'h99;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_ae",    int'(almost_empty), 1);
        chk("mid_rst_dout",  int'(data_out), 0);
        w_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h66, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_first", int'(data_out), 'h55);

        // random traffic against the model
        for (int i = 0; i < 10000; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
